// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball position controller: samples direction buttons on the
// Vsync rising edge, steps and clamps the centre, and doubles the step while held.

module ball_axis_step #(
  parameter int W      = 11,
  parameter int SW     = 3,
  parameter int LIMIT  = 1280,
  parameter int RADIUS = 10
) (
  input  logic [W-1:0]  cur,
  input  logic          inc,
  input  logic          dec,
  input  logic [SW-1:0] step,
  output logic [W-1:0]  nxt
);
  localparam int AW = 13;
  localparam logic signed [AW-1:0] LO = AW'(RADIUS);
  localparam logic signed [AW-1:0] HI = AW'(LIMIT - 1 - RADIUS);

  logic signed [AW-1:0] cur_s, step_s, t, c;

  assign cur_s  = {{(AW-W){1'b0}}, cur};
  assign step_s = {{(AW-SW){1'b0}}, step};

  // Opposing presses cancel; signed headroom lets x - step go below zero before clamping.
  always_comb begin
    t = cur_s;
    if (inc && !dec)      t = cur_s + step_s;
    else if (dec && !inc) t = cur_s - step_s;
  end

  always_comb begin
    c = t;
    if (t < LO)      c = LO;
    else if (t > HI) c = HI;
  end

  assign nxt = c[W-1:0];
endmodule

module ball_motion_ctrl #(
  parameter int H_VISIBLE   = 1280,
  parameter int V_VISIBLE   = 800,
  parameter int RADIUS      = 10,
  parameter int START_X     = 640,
  parameter int START_Y     = 400,
  parameter int BASE_STEP   = 2,
  parameter int HOLD_FRAMES = 8,
  parameter int XW          = 11,
  parameter int YW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Vsync,
  input  logic          btnU,
  input  logic          btnD,
  input  logic          btnL,
  input  logic          btnR,
  output logic [XW-1:0] xcenter,
  output logic [YW-1:0] ycenter,
  output logic          boost,
  output logic          update_done
);
  localparam int SW = $clog2(2*BASE_STEP + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, CALC_X, CALC_Y, COMMIT} state_t;
  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } btn_t;

  state_t          state, state_nxt;
  logic            vs_prev, frame_evt;
  logic            cap_en, calcx_en, calcy_en, commit_en;
  btn_t            btn_q;
  logic [SW-1:0]   step_q;
  logic [XW-1:0]   x_calc, x_nxt_q;
  logic [YW-1:0]   y_calc, y_nxt_q;
  logic [HW-1:0]   hold_cnt, hold_nxt;

  // Reset to 1 so a Vsync already high when reset drops is not seen as a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_prev <= 1'b1;
    else       vs_prev <= Vsync;
  end

  assign frame_evt = Vsync & ~vs_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_evt) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CALC_X;
      CALC_X:  state_nxt = CALC_Y;
      CALC_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_en    = 1'b0;
    calcx_en  = 1'b0;
    calcy_en  = 1'b0;
    commit_en = 1'b0;
    case (state)
      CAPTURE: cap_en    = 1'b1;
      CALC_X:  calcx_en  = 1'b1;
      CALC_Y:  calcy_en  = 1'b1;
      COMMIT:  commit_en = 1'b1;
      default: ;
    endcase
  end

  // Step is fixed at capture from the boost earned by the previous frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q  <= '0;
      step_q <= SW'(BASE_STEP);
    end else if (cap_en) begin
      btn_q  <= '{u: btnU, d: btnD, l: btnL, r: btnR};
      step_q <= boost ? SW'(2*BASE_STEP) : SW'(BASE_STEP);
    end
  end

  ball_axis_step #(.W(XW), .SW(SW), .LIMIT(H_VISIBLE), .RADIUS(RADIUS)) u_x (
    .cur (xcenter),
    .inc (btn_q.r),
    .dec (btn_q.l),
    .step(step_q),
    .nxt (x_calc)
  );

  ball_axis_step #(.W(YW), .SW(SW), .LIMIT(V_VISIBLE), .RADIUS(RADIUS)) u_y (
    .cur (ycenter),
    .inc (btn_q.d),
    .dec (btn_q.u),
    .step(step_q),
    .nxt (y_calc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_nxt_q <= XW'(START_X);
      y_nxt_q <= YW'(START_Y);
    end else begin
      if (calcx_en) x_nxt_q <= x_calc;
      if (calcy_en) y_nxt_q <= y_calc;
    end
  end

  // Any held button, even an opposing pair, keeps the hold count climbing.
  always_comb begin
    hold_nxt = '0;
    if (|btn_q)
      hold_nxt = (hold_cnt == HW'(HOLD_FRAMES)) ? hold_cnt : hold_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcenter     <= XW'(START_X);
      ycenter     <= YW'(START_Y);
      hold_cnt    <= '0;
      boost       <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= commit_en;
      if (commit_en) begin
        xcenter  <= x_nxt_q;
        ycenter  <= y_nxt_q;
        hold_cnt <= hold_nxt;
        boost    <= (hold_nxt == HW'(HOLD_FRAMES));
      end
    end
  end
endmodule
